mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multi-cycle memory interface between the multicycle controller/datapath and a variable-latency external memory. It turns the controller's single-state strobes (`irwrite`, `memwrite`, `iord`, `lb`) into a held request/acknowledge transaction. It stalls the controller until the memory answers and owns the instruction register (IR) and memory data register (MDR). The MDR holds load data already byte-extracted for LB/LBU.

## Interface
- `WIDTH`, 32, data word width.
- `ADDR_W`, 32, byte-address width.
- `MAX_WAIT`, 255, maximum WAIT cycles before a transaction is aborted.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at an edge resets the block.
- `irwrite` in 1: instruction-fetch request from the controller.
- `memwrite` in 1: data-write request from the controller.
- `iord` in 1: address select (1 = `aluout`, 0 = `pc`); `iord & ~memwrite & ~irwrite` is a data read.
- `lb` in 2: load width: 00 word, 01 LB (sign-extended), 10 LBU (zero-extended), 11 word.
- `pc` in ADDR_W: fetch address.
- `aluout` in ADDR_W: data address.
- `writedata` in WIDTH: store data.
- `mem_req` out 1: request valid, held until acknowledged.
- `mem_we` out 1: write enable for the current request.
- `mem_addr` out ADDR_W: word-aligned address (`addr[1:0]` forced to 00).
- `mem_wdata` out WIDTH: store data.
- `mem_rdata` in WIDTH: read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: memory completion.
- `instr` out WIDTH: IR contents.
- `data` out WIDTH: MDR contents (extracted).
- `stall` out 1: controller must hold its state while high.
- `timeout` out 1: sticky abort flag.

## Operation
- FSM states: IDLE, WAIT. Reset state is IDLE.
- Request condition, in IDLE: `req = memwrite | irwrite | iord`.
- Request kind priority: write (`memwrite`) > fetch (`irwrite`) > data read.
- IDLE with `req`:
  - Latch kind, `lb`, `addr[1:0]`, `mem_addr`, `mem_wdata`, and `mem_we = memwrite`.
  - Set `mem_req=1`, go to WAIT, clear the wait counter.
- WAIT with `mem_ack=1`:
  - Fetch: IR <= `mem_rdata`.
  - Read: MDR <= extracted `mem_rdata`.
  - Write: no capture.
  - Then `mem_req=0`, `mem_we=0`, go to IDLE.
- WAIT without ack: the counter increments. When the counter reaches `MAX_WAIT-1` with no ack:
  - Set `timeout=1` (sticky until reset).
  - Clear `mem_req`, go to IDLE.
  - IR and MDR are unchanged.
- `mem_addr`, `mem_we`, and `mem_wdata` stay stable for the whole WAIT.
- Changes on `pc`, `aluout`, or `writedata` during WAIT are ignored.
- `mem_ack` is ignored in IDLE.
- Byte extraction is little-endian, using the latched `addr[1:0]`:
  - 00 selects `rdata[7:0]`, 01 selects `[15:8]`, 10 selects `[23:16]`, 11 selects `[31:24]`.
  - LB sign-extends the selected byte to WIDTH; LBU zero-extends it.
  - Word loads ignore `addr[1:0]`.
- Stores are full-word only; `lb` has no effect on writes.
- `stall = (IDLE & req) | (WAIT & ~mem_ack & ~abort)`, combinational.
  - `abort` is true in the cycle in which the counter is at `MAX_WAIT-1`.
- While `reset==0`, `stall=0`.
- Reset values: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `instr`, `data`, `timeout` are all 0. FSM is IDLE and the counter is 0.
- Reset mid-transaction: at the reset edge, go to IDLE with `mem_req=0` and do not capture. A same-cycle `mem_ack` is discarded.

## Timing
- Request sampled in cycle N. `mem_req` is high from N+1.
- Minimum access (ack in N+1):
  - `stall` is high in N and low in N+1.
  - IR/MDR hold new data from N+2.
  - Total: 2 cycles per access.
- Ack in cycle N+k: `stall` is high for cycles N through N+k-1 and low in N+k.
- Back-to-back: a new request may be sampled in the cycle after the ack (IDLE). This gives one idle `mem_req=0` cycle between transactions.
- Timeout: with no ack, `mem_req` is high for exactly `MAX_WAIT` cycles (N+1 to N+MAX_WAIT).
  - `stall` is low in N+MAX_WAIT.
  - `timeout` is high from N+MAX_WAIT+1.
- The controller's `pcen` path is unaffected. The controller must gate its own state advance with `~stall`.

## Test plan
- Reset: hold `reset=0` for 2 cycles with `irwrite=1`. Required: all outputs 0 and `mem_req` never asserted. Release reset: a fetch starts the next cycle.
- Fetch, zero-wait: `irwrite=1`, `iord=0`, `pc=0x0000_0040`, ack in N+1 with `rdata=0x2008_0005`. Required: `mem_addr=0x40`, `mem_we=0`, `stall` high only in N, `instr=0x2008_0005` at N+2.
- Data read:
  - LB: `aluout=0x0000_0102`, `lb=01`, ack after 3 WAIT cycles with `rdata=0x1280_3456`. Required: `mem_addr=0x100`, `data=0xFFFF_FF80`, stall held 3 cycles.
  - Repeat with `lb=10`. Required: `data=0x0000_0080`.
- Store with `pc` changing during WAIT: `memwrite=1`, `iord=1`, `aluout=0x8`, `writedata=0xDEAD_BEEF`, ack after 2 WAIT cycles. Required: `mem_we=1`, `mem_wdata=0xDEAD_BEEF` stable throughout, and IR/MDR unchanged.
- Timeout (`MAX_WAIT=4`), no ack. Required: `mem_req` high exactly 4 cycles, `timeout=1` afterwards and sticky, then the next request proceeds normally.
- Reset while in WAIT, with `mem_ack=1` in the same cycle. Required: no capture, `mem_req=0` next cycle, `timeout` cleared.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Turns the multicycle controller's single-cycle memory strobes into a held
// request/acknowledge transaction towards a variable-latency memory. Owns
// the instruction register (IR) and memory data register (MDR), stalls the
// controller until the memory answers, and aborts after MAX_WAIT cycles.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   irwrite, memwrite     fetch / store strobes from the controller
//   iord                  address select (1 = aluout, 0 = pc)
//   lb                    load width: 00/11 word, 01 LB, 10 LBU
//   pc, aluout            fetch / data byte address
//   writedata             store data
//   mem_req, mem_we       request valid (held) and its write enable
//   mem_addr, mem_wdata   word-aligned address and store data
//   mem_rdata, mem_ack    read data and completion from memory
//   instr, data           IR and MDR (MDR already byte-extracted)
//   stall                 controller must hold its state while high
//   timeout               sticky abort flag
module mem_access_unit #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irwrite,
    input  logic              memwrite,
    input  logic              iord,
    input  logic [1:0]        lb,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] aluout,
    input  logic [WIDTH-1:0]  writedata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic [WIDTH-1:0]  instr,
    output logic [WIDTH-1:0]  data,
    output logic              stall,
    output logic              timeout
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic { S_IDLE, S_WAIT } state_t;
    typedef enum logic [1:0] { K_WRITE, K_FETCH, K_READ } kind_t;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic [1:0]        lb_q, lb_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0]  instr_q, instr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              timeout_q, timeout_d;
    logic              stall_c;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [4:0]        bit_off;
    logic [7:0]        byte_sel;
    logic [WIDTH-1:0]  load_val;

    assign req  = memwrite | irwrite | iord;
    assign addr = iord ? aluout : pc;

    // Little-endian byte pick using the offset latched with the request.
    always_comb begin
        bit_off  = {off_q, 3'b000};
        byte_sel = mem_rdata[bit_off +: 8];
        case (lb_q)
            2'b01:   load_val = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            2'b10:   load_val = {{(WIDTH-8){1'b0}}, byte_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        lb_d        = lb_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        instr_d     = instr_q;
        data_d      = data_q;
        timeout_d   = timeout_q;
        stall_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    stall_c     = 1'b1;
                    kind_d      = memwrite ? K_WRITE : (irwrite ? K_FETCH : K_READ);
                    lb_d        = lb;
                    off_d       = addr[1:0];
                    mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = writedata;
                    mem_we_d    = memwrite;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack arriving in the last allowed cycle still completes.
                if (mem_ack) begin
                    if (kind_q == K_FETCH) instr_d = mem_rdata;
                    if (kind_q == K_READ)  data_d  = load_val;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            kind_q      <= K_WRITE;
            lb_q        <= 2'b00;
            off_q       <= 2'b00;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            instr_q     <= '0;
            data_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            lb_q        <= lb_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            instr_q     <= instr_d;
            data_q      <= data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign instr     = instr_q;
    assign data      = data_q;
    assign timeout   = timeout_q;
    // The controller is never held while the block is in reset.
    assign stall     = reset & stall_c;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam int WIDTH = 32;
    localparam int ADDR_W = 32;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        irwrite = 1'b0, memwrite = 1'b0, iord = 1'b0;
    logic [1:0]  lb = 2'b00;
    logic [31:0] pc = '0, aluout = '0, writedata = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, stall, timeout;
    logic [31:0] mem_addr, mem_wdata, instr, data;

    mem_access_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .irwrite(irwrite), .memwrite(memwrite),
        .iord(iord), .lb(lb), .pc(pc), .aluout(aluout), .writedata(writedata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instr(instr), .data(data), .stall(stall), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_instr = '0;
    logic [31:0] exp_data = '0;
    logic        exp_timeout = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Load result computed from the byte address and load width.
    function automatic logic [31:0] ref_load(input logic [1:0] lbv, input logic [31:0] a,
                                             input logic [31:0] rd);
        int unsigned sh;
        logic [31:0] b;
        sh = 8 * (a % 4);
        b = (rd >> sh) & 32'hFF;
        if (lbv == 2'd1) return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
        if (lbv == 2'd2) return b;
        return rd;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_instr"}, instr, exp_instr);
        check({tag, "_data"}, data, exp_data);
        check({tag, "_timeout"}, timeout, exp_timeout);
    endtask

    // Issue one request in the current cycle; ack in WAIT cycle k (k=0: never).
    task automatic run_txn(input logic irw, input logic mw, input logic io,
                           input logic [1:0] lbv, input logic [31:0] pcv,
                           input logic [31:0] av, input logic [31:0] wd,
                           input logic [31:0] rd, input int k);
        logic [31:0] baddr;
        logic        is_fetch;
        int          held;
        baddr    = io ? av : pcv;
        is_fetch = !mw && irw;
        held     = 0;
        irwrite = irw; memwrite = mw; iord = io; lb = lbv;
        pc = pcv; aluout = av; writedata = wd; mem_ack = 1'b0;
        @(negedge clk);
        check("req_stall", stall, 1);
        check("req_mem_req_low", mem_req, 0);
        for (int i = 1; i <= MW; i++) begin
            next_cycle();
            irwrite = 1'b0; memwrite = 1'b0; iord = 1'($urandom); lb = 2'($urandom);
            pc = $urandom; aluout = $urandom; writedata = $urandom;
            mem_ack = (i == k);
            mem_rdata = (i == k) ? rd : $urandom;
            @(negedge clk);
            held++;
            check("wait_mem_req", mem_req, 1);
            check("wait_mem_addr", mem_addr, baddr & 32'hFFFF_FFFC);
            check("wait_mem_we", mem_we, mw);
            check("wait_mem_wdata", mem_wdata, wd);
            check("wait_stall", stall, ((i != k) && (i != MW)) ? 1 : 0);
            if (i == k) break;
        end
        next_cycle();
        mem_ack = 1'b0; iord = 1'b0;
        if (k == 0) exp_timeout = 1'b1;
        else if (is_fetch) exp_instr = rd;
        else if (!mw) exp_data = ref_load(lbv, baddr, rd);
        @(negedge clk);
        check_idle("done");
        $display("[TB] txn %s addr=0x%08h lb=%0d ack_k=%0d req_cycles=%0d instr=0x%08h data=0x%08h timeout=%0d",
                 mw ? "WRITE" : (irw ? "FETCH" : "READ "), baddr, lbv, k, held, instr, data, timeout);
    endtask

    initial begin
        logic [31:0] rd;
        logic        r_irw, r_mw, r_io;

        // Reset held with a fetch strobe present.
        reset = 1'b0; irwrite = 1'b1; pc = 32'h40;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_mem_req", mem_req, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_stall", stall, 0);
            check("rst_instr", instr, 0);
            check("rst_data", data, 0);
            check("rst_timeout", timeout, 0);
        end
        next_cycle();
        reset = 1'b1;
        // Zero-wait fetch.
        run_txn(1, 0, 0, 2'b00, 32'h0000_0040, 32'h0, 32'h0, 32'h2008_0005, 1);
        // LB / LBU with 3-cycle stall.
        next_cycle();
        run_txn(0, 0, 1, 2'b01, 32'h0, 32'h0000_0102, 32'h0, 32'h1280_3456, 3);
        next_cycle();
        run_txn(0, 0, 1, 2'b10, 32'h0, 32'h0000_0102, 32'h0, 32'h1280_3456, 3);
        // Store, pc changing during WAIT.
        next_cycle();
        run_txn(0, 1, 1, 2'b01, 32'h0000_0200, 32'h0000_0008, 32'hDEAD_BEEF, 32'h5555_AAAA, 2);
        // Timeout then a normal fetch (timeout stays set).
        next_cycle();
        run_txn(1, 0, 0, 2'b00, 32'h0000_0080, 32'h0, 32'h0, 32'h0BAD_0BAD, 0);
        next_cycle();
        run_txn(1, 0, 0, 2'b00, 32'h0000_0084, 32'h0, 32'h0, 32'h1234_5678, 2);

        // Randomized transactions, with occasional stray acks in IDLE.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                next_cycle();
                mem_ack = 1'b1; mem_rdata = $urandom;
                @(negedge clk);
                check_idle("idle_ack");
            end
            r_irw = 1'($urandom); r_mw = 1'($urandom); r_io = 1'($urandom);
            if (!r_irw && !r_mw) r_io = 1'b1;
            rd = $urandom;
            next_cycle();
            run_txn(r_irw, r_mw, r_io, 2'($urandom), $urandom, $urandom, $urandom, rd,
                    ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3)));
        end

        // Reset during WAIT with a same-cycle ack.
        next_cycle();
        irwrite = 1'b1; iord = 1'b0; memwrite = 1'b0; pc = 32'h0000_0100;
        @(negedge clk);
        check("rstw_req_stall", stall, 1);
        next_cycle();
        irwrite = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; reset = 1'b0;
        @(negedge clk);
        check("rstw_stall_in_reset", stall, 0);
        check("rstw_mem_req_before", mem_req, 1);
        next_cycle();
        mem_ack = 1'b0;
        exp_instr = '0; exp_data = '0; exp_timeout = 1'b0;
        @(negedge clk);
        check_idle("rstw_after");
        next_cycle();
        reset = 1'b1;
        run_txn(1, 0, 0, 2'b00, 32'h0000_0044, 32'h0, 32'h0, 32'h8765_4321, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
